addsub_acc_unit: RTL and testbench
==================================

ADDSUB_ACC_UNIT -- requirements
Module: addsub_acc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 2..64).
REQ-002 SHALL have parameter OP_W, default 4, fixed one-hot opcode width.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1 (rising edge), rst_n input 1 (async assert, active-low).
REQ-004 SHALL have ports:
- in_valid input 1: request present.
- in_ready output 1: request accepted when high with in_valid.
- op1 input WIDTH: first operand.
- op2 input WIDTH: second operand.
- select input 4: one-hot op; bit0 add, bit1 sub, bit2 inc, bit3 dec.
- acc_mode input 1: substitute accumulator for op1 and write the result back.
- acc_clr input 1: synchronous accumulator clear.
- out_valid output 1: result register full.
- out_ready input 1: consumer takes result.
- result output WIDTH: registered result.
- flags output 5: {err,v,n,z,c}.
- acc output WIDTH: accumulator value.

Function
REQ-005 SHALL compute the sum with one WIDTH-bit adder: add op1+op2+0; sub op1+~op2+1; inc op1+1; dec op1+all-ones.
REQ-006 SHALL drive c as the adder carry-out; for sub, c=1 means no borrow.
REQ-007 SHALL set z when result==0, n as result[WIDTH-1], and v as two's-complement signed overflow of the performed addition.
REQ-008 SHALL, for select==0, produce result 0 with flags z=1 and all others 0.
REQ-009 SHALL, for any select with more than one bit set, produce result 0 with err=1 and z=1.
REQ-010 SHALL have 1-cycle latency: a request accepted at edge k gives out_valid=1 with result/flags after edge k.
REQ-011 SHALL hold result/flags stable while out_valid=1 and out_ready=0.
REQ-012 SHALL drive in_ready = !acc_clr && (!out_valid || out_ready), giving full throughput of one op per cycle under continuous out_ready.
REQ-013 SHALL clear out_valid on an edge with out_valid && out_ready and no accept.
REQ-014 SHALL have two output states: EMPTY (out_valid=0) and FULL (out_valid=1).
- EMPTY->FULL on accept.
- FULL->EMPTY on drain without accept.
- FULL->FULL on simultaneous drain and accept.
REQ-015 SHALL, when acc_mode=1 at accept, use acc in place of op1 and load acc with the new result on the same edge.
REQ-016 SHALL leave acc unchanged when acc_mode=0.
REQ-017 SHALL zero acc on an edge with acc_clr=1; in_ready=0 that cycle, so clear never collides with an accumulate.
REQ-018 SHALL not update acc for err transactions.

Reset
REQ-019 SHALL, while rst_n=0, force out_valid=0, result=0, flags=0 and acc=0 asynchronously.
REQ-020 SHALL discard any undrained result when reset asserts mid-operation, and accept nothing until the first edge after rst_n deasserts.

Configuration
REQ-021 SHALL, with ADDSUB_ACC_SAT_EN defined, replace an overflowing result (v=1) with a saturated value:
- positive overflow -> 0 followed by WIDTH-1 ones (max signed).
- negative overflow -> 1 followed by WIDTH-1 zeros (min signed).
- v stays 1; acc loads the saturated value.
REQ-022 SHALL, without ADDSUB_ACC_SAT_EN, wrap modulo 2^WIDTH, with no saturation logic present.

Structure
REQ-023 SHALL place in shared package arith_pkg:
- select bit index constants OP_ADD=0, OP_SUB=1, OP_INC=2, OP_DEC=3.
- flag bit index constants F_C=0, F_Z=1, F_N=2, F_V=3, F_ERR=4.
REQ-024 SHALL instantiate one combinational sub-module addsub_core (operand mux, adder, flag generation), with handshake, output register and accumulator in the top.

Verification (WIDTH=8)
REQ-025 SHALL cover: add 8'h7F+8'h01 -> result 8'h80, v=1, n=1, c=0; with SAT_EN -> 8'h7F, v=1.
REQ-026 SHALL cover: sub 8'h05-8'h07 -> 8'hFE, c=0, n=1; sub 8'h07-8'h07 -> 8'h00, z=1, c=1.
REQ-027 SHALL cover: select=4'b0110 -> result 0, err=1, acc unchanged; select=0 -> result 0, z=1, err=0.
REQ-028 SHALL cover: acc_mode with inc x3 from cleared acc -> acc=3 and results 1,2,3 on consecutive cycles; then dec from 0 -> 8'hFF.
REQ-029 SHALL cover: out_ready held low 3 cycles with in_valid high -> in_ready=0, result stable, then drain+accept same edge keeps out_valid=1 with no data lost.
REQ-030 SHALL cover: rst_n pulsed low while FULL with acc=8'h2A -> out_valid=0, acc=0 immediately; acc_clr with in_valid -> in_ready=0 and acc=0 next edge.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic constants: one-hot opcode bit positions and flag bit
// positions for the {err,v,n,z,c} flag vector, plus the output-register states.
package arith_pkg;
    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_INC = 2;
    localparam int OP_DEC = 3;

    localparam int F_C   = 0;
    localparam int F_Z   = 1;
    localparam int F_N   = 2;
    localparam int F_V   = 3;
    localparam int F_ERR = 4;
    localparam int F_W   = 5;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ostate_t;
endpackage

// File: rtl/addsub_core.sv
// Combinational add/sub/inc/dec core: operand mux, single adder, flags.
// Optional saturation on signed overflow when ADDSUB_ACC_SAT_EN is defined;
// otherwise results wrap modulo 2^WIDTH.
module addsub_core
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  select,
    output logic [WIDTH-1:0] result,
    output logic [F_W-1:0]   flags
);
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             v;
    logic             c;
    logic             none;
    logic             multi;

    // Pick the second adder operand and carry-in so every op shares one adder
    always_comb begin
        b_eff = b;
        cin   = 1'b0;
        if (select[OP_ADD]) begin
            b_eff = b;
        end else if (select[OP_SUB]) begin
            b_eff = ~b;
            cin   = 1'b1;
        end else if (select[OP_INC]) begin
            b_eff = '0;
            cin   = 1'b1;
        end else if (select[OP_DEC]) begin
            b_eff = '1;
        end
    end

    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    assign c     = sum[WIDTH];
    // Overflow: both addends share a sign that the sum does not
    assign v     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign none  = (select == '0);
    assign multi = |(select & (select - {{(OP_W-1){1'b0}}, 1'b1}));

`ifdef ADDSUB_ACC_SAT_EN
    // Clamp toward the sign of the operands on overflow
    assign res = !v ? sum[WIDTH-1:0]
               : (a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign res = sum[WIDTH-1:0];
`endif

    // Final result and flags; no-op and illegal selects force a zero result
    always_comb begin
        result = '0;
        flags  = '0;
        if (none || multi) begin
            flags[F_Z]   = 1'b1;
            flags[F_ERR] = multi;
        end else begin
            result     = res;
            flags[F_C] = c;
            flags[F_Z] = (res == '0);
            flags[F_N] = res[WIDTH-1];
            flags[F_V] = v;
        end
    end
endmodule

// File: rtl/addsub_acc_unit.sv
// Add/sub accumulator unit: valid/ready handshake, one-entry result register
// and an accumulator that can replace op1. Build option ADDSUB_ACC_SAT_EN
// enables saturation on signed overflow (handled inside addsub_core).
module addsub_acc_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [OP_W-1:0]  select,
    input  logic             acc_mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [F_W-1:0]   flags,
    output logic [WIDTH-1:0] acc
);
    ostate_t          state;
    logic             accept;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_res;
    logic [F_W-1:0]   core_flags;

    // A clear cycle blocks acceptance so it never races an accumulate
    assign in_ready  = !acc_clr && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign core_a    = acc_mode ? acc : op1;
    assign out_valid = (state == FULL);

    addsub_core #(.WIDTH(WIDTH), .OP_W(OP_W)) u_core (
        .a      (core_a),
        .b      (op2),
        .select (select),
        .result (core_res),
        .flags  (core_flags)
    );

    // Output register FSM: load on accept, empty on drain without a new accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            result <= '0;
            flags  <= '0;
        end else begin
            case (state)
                EMPTY: if (accept) state <= FULL;
                FULL:  if (out_ready && !accept) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            if (accept) begin
                result <= core_res;
                flags  <= core_flags;
            end
        end
    end

    // Accumulator: clear wins; write back only non-error accumulate ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (accept && acc_mode && !core_flags[F_ERR]) begin
            acc <= core_res;
        end
    end
endmodule

// File: tb/tb_addsub_acc_unit.sv
// Directed bench for addsub_acc_unit at WIDTH=8: table of single-op vectors
// followed by hand-written accumulator, backpressure and reset sequences.
module tb_addsub_acc_unit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready;
    logic [W-1:0] op1, op2;
    logic [3:0]   select;
    logic         acc_mode, acc_clr;
    logic         out_valid, out_ready;
    logic [W-1:0] result, acc;
    logic [4:0]   flags;

    int n_checks = 0;
    int n_fail   = 0;

    addsub_acc_unit #(.WIDTH(W), .OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .select(select), .acc_mode(acc_mode),
        .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .acc(acc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [4:0] flg;   // {err,v,n,z,c}
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(string n, logic [3:0] s, logic [7:0] a, logic [7:0] b,
                                logic [7:0] r, logic [4:0] f);
        vec_t t;
        t.name = n; t.sel = s; t.a = a; t.b = b; t.res = r; t.flg = f;
        return t;
    endfunction

    initial begin
        vecs[0]  = mk("add_7f_01",  4'b0001, 8'h7F, 8'h01,
`ifdef ADDSUB_ACC_SAT_EN
                      8'h7F, 5'b01000);
`else
                      8'h80, 5'b01100);
`endif
        vecs[1]  = mk("sub_05_07",  4'b0010, 8'h05, 8'h07, 8'hFE, 5'b00100);
        vecs[2]  = mk("sub_07_07",  4'b0010, 8'h07, 8'h07, 8'h00, 5'b00011);
        vecs[3]  = mk("add_03_04",  4'b0001, 8'h03, 8'h04, 8'h07, 5'b00000);
        vecs[4]  = mk("add_ff_01",  4'b0001, 8'hFF, 8'h01, 8'h00, 5'b00011);
        vecs[5]  = mk("add_80_80",  4'b0001, 8'h80, 8'h80,
`ifdef ADDSUB_ACC_SAT_EN
                      8'h80, 5'b01101);
`else
                      8'h00, 5'b01011);
`endif
        vecs[6]  = mk("inc_10",     4'b0100, 8'h10, 8'h55, 8'h11, 5'b00000);
        vecs[7]  = mk("inc_ff",     4'b0100, 8'hFF, 8'h00, 8'h00, 5'b00011);
        vecs[8]  = mk("dec_00",     4'b1000, 8'h00, 8'h33, 8'hFF, 5'b00100);
        vecs[9]  = mk("dec_80",     4'b1000, 8'h80, 8'h00,
`ifdef ADDSUB_ACC_SAT_EN
                      8'h80, 5'b01101);
`else
                      8'h7F, 5'b01001);
`endif
        vecs[10] = mk("dec_05",     4'b1000, 8'h05, 8'h00, 8'h04, 5'b00001);
        vecs[11] = mk("sel_0110",   4'b0110, 8'h12, 8'h34, 8'h00, 5'b10010);
        vecs[12] = mk("sel_0000",   4'b0000, 8'h12, 8'h34, 8'h00, 5'b00010);
        vecs[13] = mk("sel_1111",   4'b1111, 8'hAA, 8'h55, 8'h00, 5'b10010);
        vecs[14] = mk("sub_80_01",  4'b0010, 8'h80, 8'h01,
`ifdef ADDSUB_ACC_SAT_EN
                      8'h80, 5'b01101);
`else
                      8'h7F, 5'b01001);
`endif

        rst_n = 1'b0; in_valid = 1'b0; op1 = '0; op2 = '0; select = '0;
        acc_mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_acc", acc, 0);
        rst_n = 1'b1;
        step();

        // Table vectors: back-to-back accepts with continuous out_ready
        foreach (vecs[i]) begin
            in_valid = 1'b1; select = vecs[i].sel; op1 = vecs[i].a; op2 = vecs[i].b;
            #1;
            chk({vecs[i].name, "_in_ready"}, in_ready, 1);
            step();
            chk({vecs[i].name, "_valid"}, out_valid, 1);
            chk({vecs[i].name, "_result"}, result, vecs[i].res);
            chk({vecs[i].name, "_flags"}, flags, vecs[i].flg);
            chk({vecs[i].name, "_acc"}, acc, 0);
        end

        // Accumulate: clear, then inc x3 from zero
        acc_clr = 1'b1; #1;
        chk("clr_in_ready", in_ready, 0);
        step();
        chk("clr_drained", out_valid, 0);
        chk("clr_acc", acc, 0);
        acc_clr = 1'b0; acc_mode = 1'b1; select = 4'b0100; op1 = 8'hC3;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("acc_inc_result", result, k);
            chk("acc_inc_acc", acc, k);
            chk("acc_inc_valid", out_valid, 1);
        end
        // Clear again, then dec from 0
        acc_clr = 1'b1; step();
        chk("clr2_acc", acc, 0);
        acc_clr = 1'b0; select = 4'b1000; step();
        chk("acc_dec_result", result, 8'hFF);
        chk("acc_dec_acc", acc, 8'hFF);
        // Error op in accumulate mode leaves acc alone
        select = 4'b0110; step();
        chk("acc_err_flags", flags, 5'b10010);
        chk("acc_err_acc", acc, 8'hFF);
        // Clear while a request is offered: not accepted, acc zeroed
        select = 4'b0001; op2 = 8'h01; acc_clr = 1'b1; #1;
        chk("clr3_in_ready", in_ready, 0);
        step();
        chk("clr3_acc", acc, 0);
        chk("clr3_valid", out_valid, 0);
        acc_clr = 1'b0; acc_mode = 1'b0;

        // Backpressure: hold a result while out_ready is low
        select = 4'b0001; op1 = 8'h01; op2 = 8'h02; in_valid = 1'b1; step();
        chk("bp_first", result, 8'h03);
        out_ready = 1'b0; op1 = 8'h10; op2 = 8'h20;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            step();
            chk("bp_hold_result", result, 8'h03);
            chk("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1; #1;
        chk("bp_release_ready", in_ready, 1);
        step();
        chk("bp_swap_valid", out_valid, 1);
        chk("bp_swap_result", result, 8'h30);
        in_valid = 1'b0; step();
        chk("bp_drain_valid", out_valid, 0);

        // Reset while FULL with acc = 2A
        acc_mode = 1'b1; select = 4'b0001; op2 = 8'h2A; in_valid = 1'b1; step();
        chk("pre_rst_acc", acc, 8'h2A);
        in_valid = 1'b0; out_ready = 1'b0; step();
        chk("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0; #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_acc", acc, 0);
        chk("async_rst_result", result, 0);
        in_valid = 1'b1; out_ready = 1'b1; acc_mode = 1'b0; op1 = 8'h05; op2 = 8'h06;
        step();
        chk("in_rst_no_accept", out_valid, 0);
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_result", result, 8'h0B);
        in_valid = 1'b0; step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
